ecc_57_enc_fault_detc: RTL and testbench

Write-side counterpart of the 57-bit SECDED fault-detecting decoder. It accepts 57-bit data beats over a valid/ready handshake and encodes each beat with two lockstep encoder instances. The parities from the two instances are compared, and a one-deep registered output stage delivers {data, parity} to the FIFO/RAM write port. It supports fault flagging with poisoning, a saturating fault counter, and one-shot error injection for decoder verification.

---
 rtl/ecc_57_pkg.sv | 40 ++++
 rtl/ecc_57_enc.sv | 23 ++
 rtl/ecc_57_enc_fault_detc.sv | 94 +++++++++
 tb/tb_ecc_57_enc_fault_detc.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_57_pkg.sv
// Shared definitions for the 57-bit SECDED encoder/decoder pair.
// Holds the codeword layout, poison mask and injection mode encodings.
package ecc_57_pkg;

   localparam int unsigned DATA_WIDTH   = 57;
   localparam int unsigned PARITY_WIDTH = 7;
   localparam int unsigned HAM_WIDTH    = 6;
   localparam int unsigned POS_WIDTH    = 6;

   // Flipping parity bits 0 and 6 yields syndrome 1 with even overall parity: a double error.
   localparam logic [PARITY_WIDTH-1:0] POISON_MASK = 7'b1000001;

   typedef enum logic [1:0] {
      INJ_NONE   = 2'b00,
      INJ_SINGLE = 2'b01,
      INJ_DOUBLE = 2'b10,
      INJ_RSVD   = 2'b11
   } inj_mode_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0]   data;
      logic [PARITY_WIDTH-1:0] parity;
   } beat_t;

   // Codeword position of data bit idx: the idx-th non-power-of-2 position from 3 upward.
   function automatic logic [POS_WIDTH-1:0] data_pos(input int unsigned idx);
      int unsigned cnt;
      logic [POS_WIDTH-1:0] pos;
      cnt = 0;
      pos = '0;
      for (int unsigned p = 3; p < 64; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == idx) pos = POS_WIDTH'(p);
            cnt++;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/ecc_57_enc.sv
// Combinational SECDED encoder: 57 data bits -> 6 Hamming checks plus overall parity.
module ecc_57_enc
   import ecc_57_pkg::*;
(
   input  logic [DATA_WIDTH-1:0]   data,
   output logic [PARITY_WIDTH-1:0] parity
);

   always_comb begin
      logic [HAM_WIDTH-1:0] ham;
      logic [POS_WIDTH-1:0] pos;
      ham = '0;
      pos = '0;
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
         pos = data_pos(i);
         for (int unsigned k = 0; k < HAM_WIDTH; k++) begin
            if (pos[k]) ham[k] = ham[k] ^ data[i];
         end
      end
      parity = {(^data) ^ (^ham), ham};
   end

endmodule

// File: rtl/ecc_57_enc_fault_detc.sv
// Lockstep SECDED write-side encoder with fault poisoning, saturating fault counter
// and one-shot data error injection, behind a one-deep valid/ready output register.
module ecc_57_enc_fault_detc
   import ecc_57_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ecc_fault_detc_en,
   input  logic                    bypass,
   input  logic                    in_vld,
   output logic                    in_rdy,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    out_vld,
   input  logic                    out_rdy,
   output logic [DATA_WIDTH-1:0]   data_out,
   output logic [PARITY_WIDTH-1:0] parity_out,
   output logic                    ecc_fault,
   output logic                    fault_sticky,
   output logic [CNT_WIDTH-1:0]    fault_cnt,
   input  logic                    fault_clr,
   input  logic                    inj_arm,
   input  logic [1:0]              inj_mode,
   input  logic [5:0]              inj_pos,
   output logic                    inj_armed
);

   logic [PARITY_WIDTH-1:0] p0;
   logic [PARITY_WIDTH-1:0] p1;
   logic                    accept;
   logic                    mismatch;
   logic                    fault_hit;
   logic [DATA_WIDTH-1:0]   inj_mask;
   logic [5:0]              inj_next;
   beat_t                   beat_q;

   ecc_57_enc u0_ecc_57_enc (.data(data_in), .parity(p0));
   ecc_57_enc u1_ecc_57_enc (.data(data_in), .parity(p1));

   assign in_rdy     = ~out_vld | out_rdy;
   assign accept     = in_vld & in_rdy;
   assign mismatch   = (p0 != p1) & ecc_fault_detc_en & ~bypass;
   assign fault_hit  = accept & mismatch;
   assign data_out   = beat_q.data;
   assign parity_out = beat_q.parity;

   // Flip mask for a pending injection; out-of-range positions flip nothing.
   always_comb begin
      inj_mask = '0;
      inj_next = (inj_pos == 6'(DATA_WIDTH - 1)) ? 6'd0 : inj_pos + 6'd1;
      if (inj_armed && (inj_pos <= 6'(DATA_WIDTH - 1))) begin
         if ((inj_mode == INJ_SINGLE) || (inj_mode == INJ_DOUBLE)) inj_mask[inj_pos] = 1'b1;
         if (inj_mode == INJ_DOUBLE) inj_mask[inj_next] = 1'b1;
      end
   end

   // One-deep output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld   <= 1'b0;
         beat_q    <= '0;
         ecc_fault <= 1'b0;
      end else if (accept) begin
         out_vld       <= 1'b1;
         beat_q.data   <= data_in ^ inj_mask;
         beat_q.parity <= bypass ? '0 : (mismatch ? (p0 ^ POISON_MASK) : p0);
         ecc_fault     <= mismatch;
      end else if (out_rdy) begin
         out_vld <= 1'b0;
      end
   end

   // An arm in the accepting cycle re-arms for the following beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inj_armed <= 1'b0;
      else        inj_armed <= inj_arm | (inj_armed & ~accept);
   end

   // Clear wins but still keeps this cycle's faulted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_sticky <= 1'b0;
         fault_cnt    <= '0;
      end else if (fault_clr) begin
         fault_sticky <= fault_hit;
         fault_cnt    <= CNT_WIDTH'(fault_hit);
      end else if (fault_hit) begin
         fault_sticky <= 1'b1;
         if (fault_cnt != '1) fault_cnt <= fault_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_ecc_57_enc_fault_detc.sv
// Scoreboard bench for the lockstep SECDED encoder: driver queues expected beats,
// a negedge monitor pops on each output transfer and loops the beat through a reference decoder.
module tb_ecc_57_enc_fault_detc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        byp;
   logic        in_vld;
   logic        in_rdy;
   logic [56:0] data_in;
   logic        out_vld;
   logic        out_rdy;
   logic [56:0] data_out;
   logic [6:0]  parity_out;
   logic        ecc_fault;
   logic        fault_sticky;
   logic [7:0]  fault_cnt;
   logic        fault_clr;
   logic        inj_arm;
   logic [1:0]  inj_mode;
   logic [5:0]  inj_pos;
   logic        inj_armed;

   typedef struct {
      logic [56:0] data;
      logic [6:0]  parity;
      logic        fault;
      logic [56:0] orig;
      int          cls;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          rdy_mode = 0;
   logic [6:0]  fp;

   ecc_57_enc_fault_detc dut (
      .clk(clk), .rst_n(rst_n), .ecc_fault_detc_en(en), .bypass(byp),
      .in_vld(in_vld), .in_rdy(in_rdy), .data_in(data_in),
      .out_vld(out_vld), .out_rdy(out_rdy), .data_out(data_out), .parity_out(parity_out),
      .ecc_fault(ecc_fault), .fault_sticky(fault_sticky), .fault_cnt(fault_cnt),
      .fault_clr(fault_clr), .inj_arm(inj_arm), .inj_mode(inj_mode), .inj_pos(inj_pos),
      .inj_armed(inj_armed)
   );

   always #5 clk = ~clk;

   // Position by skipping over each power of two the running position reaches.
   function automatic logic [5:0] ref_pos(input int idx);
      int p;
      p = idx + 3;
      if (p >= 4)  p++;
      if (p >= 8)  p++;
      if (p >= 16) p++;
      if (p >= 32) p++;
      return 6'(p);
   endfunction

   function automatic logic [6:0] model_par(input logic [56:0] d);
      logic [5:0] s;
      s = '0;
      for (int i = 0; i < 57; i++) if (d[i]) s = s ^ ref_pos(i);
      return {(^d) ^ (^s), s};
   endfunction

   // 0 clean, 1 single (corrected into fixed), 2 double.
   function automatic int decode_cls(input logic [56:0] d, input logic [6:0] p,
                                     output logic [56:0] fixed);
      logic [5:0] s;
      logic       ov;
      s     = p[5:0];
      fixed = d;
      for (int i = 0; i < 57; i++) if (d[i]) s = s ^ ref_pos(i);
      ov = (^d) ^ (^p);
      if (!ov && s == 6'd0) return 0;
      if (ov) begin
         for (int i = 0; i < 57; i++) if (ref_pos(i) == s) fixed[i] = ~fixed[i];
         return 1;
      end
      return 2;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops on every transfer, checks held beats stay stable.
   initial begin : monitor
      logic        hold;
      logic [56:0] h_data;
      logic [6:0]  h_par;
      logic        h_flt;
      exp_t        e;
      logic [56:0] fixed;
      int          c;
      hold = 1'b0;
      h_data = '0;
      h_par = '0;
      h_flt = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("stall_vld",    64'(out_vld),    64'(1));
               check("stall_data",   64'(data_out),   64'(h_data));
               check("stall_parity", 64'(parity_out), 64'(h_par));
               check("stall_fault",  64'(ecc_fault),  64'(h_flt));
            end
            if (out_vld && out_rdy) begin
               hold = 1'b0;
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_empty: got unexpected beat %0h expected none", data_out);
               end else begin
                  e = sb.pop_front();
                  check("data",   64'(data_out),   64'(e.data));
                  check("parity", 64'(parity_out), 64'(e.parity));
                  check("fault",  64'(ecc_fault),  64'(e.fault));
                  if (e.cls >= 0) begin
                     c = decode_cls(data_out, parity_out, fixed);
                     check("loop_cls", 64'(c), 64'(e.cls));
                     if (e.cls == 1) check("loop_fix", 64'(fixed), 64'(e.orig));
                  end
               end
            end else if (out_vld) begin
               hold   = 1'b1;
               h_data = data_out;
               h_par  = parity_out;
               h_flt  = ecc_fault;
            end else begin
               hold = 1'b0;
            end
         end
      end
   end

   initial begin : rdy_gen
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       out_rdy = 1'b1;
            1:       out_rdy = 1'($urandom_range(0, 1));
            default: out_rdy = 1'b0;
         endcase
      end
   end

   // Issue one beat; expected parity from hand value or reference model.
   task automatic send(input logic [56:0] d, input logic [56:0] mask, input logic mm,
                       input logic clr, input logic use_hand, input logic [6:0] hand_p);
      exp_t       e;
      logic       acc;
      logic [6:0] p0;
      int         n;
      p0       = use_hand ? hand_p : model_par(d);
      e.fault  = mm & en & ~byp;
      e.parity = byp ? 7'h00 : (e.fault ? (p0 ^ 7'h41) : p0);
      e.data   = d ^ mask;
      e.orig   = d;
      if (byp)                                      e.cls = -1;
      else if (e.fault || $countones(mask) == 2)    e.cls = 2;
      else if ($countones(mask) == 1)               e.cls = 1;
      else                                          e.cls = 0;
      data_in   = d;
      in_vld    = 1'b1;
      fault_clr = clr;
      if (mm) begin
         fp = model_par(d) ^ 7'h04;
         force dut.p1 = fp;
      end
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
         @(negedge clk);
         acc = in_rdy;
         if (acc) sb.push_back(e);
         @(posedge clk);
         #1;
         n++;
         if (n > 200) begin
            n_fail++;
            $display("FAIL accept_timeout: got no acceptance expected one within 200 cycles");
            $fatal(1, "accept timeout");
         end
      end
      in_vld    = 1'b0;
      fault_clr = 1'b0;
      if (mm) release dut.p1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain", 64'(sb.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   task automatic arm();
      inj_arm = 1'b1;
      @(posedge clk);
      #1;
      inj_arm = 1'b0;
   endtask

   initial begin : main
      logic [56:0] z;
      logic [56:0] m;
      logic [56:0] d;
      z = '0;
      rst_n = 1'b0; en = 1'b1; byp = 1'b0; in_vld = 1'b0; data_in = '0; out_rdy = 1'b1;
      fault_clr = 1'b0; inj_arm = 1'b0; inj_mode = 2'b00; inj_pos = 6'd0; fp = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_vld", 64'(out_vld),      64'(0));
      check("rst_data",    64'(data_out),     64'(0));
      check("rst_parity",  64'(parity_out),   64'(0));
      check("rst_fault",   64'(ecc_fault),    64'(0));
      check("rst_sticky",  64'(fault_sticky), 64'(0));
      check("rst_cnt",     64'(fault_cnt),    64'(0));
      check("rst_armed",   64'(inj_armed),    64'(0));
      @(posedge clk);
      #1;

      // Hand-computed codewords.
      send(57'h0,           z, 1'b0, 1'b0, 1'b1, 7'h00);
      send(57'h1,           z, 1'b0, 1'b0, 1'b1, 7'h43);
      send(57'h2,           z, 1'b0, 1'b0, 1'b1, 7'h45);
      send(57'h4,           z, 1'b0, 1'b0, 1'b1, 7'h46);
      send(57'h8,           z, 1'b0, 1'b0, 1'b1, 7'h07);
      send(57'h100000000000000, z, 1'b0, 1'b0, 1'b1, 7'h7F);
      drain();

      // Random stream under random backpressure.
      rdy_mode = 1;
      for (int i = 0; i < 100; i++) begin
         d = 57'({$urandom, $urandom});
         send(d, z, 1'b0, 1'b0, 1'b0, 7'h00);
      end
      drain();
      rdy_mode = 0;
      @(posedge clk);
      #1;

      // Lockstep mismatch, enabled and disabled.
      send(57'h123456789, z, 1'b1, 1'b0, 1'b0, 7'h00);
      drain();
      check("flt_sticky", 64'(fault_sticky), 64'(1));
      check("flt_cnt",    64'(fault_cnt),    64'(1));
      en = 1'b0;
      send(57'h0ABCDEF, z, 1'b1, 1'b0, 1'b0, 7'h00);
      drain();
      check("dis_cnt", 64'(fault_cnt), 64'(1));
      en = 1'b1;
      fault_clr = 1'b1;
      @(posedge clk);
      #1;
      fault_clr = 1'b0;
      check("clr_sticky", 64'(fault_sticky), 64'(0));
      check("clr_cnt",    64'(fault_cnt),    64'(0));

      // Saturation and clear-with-fault.
      for (int i = 0; i < 300; i++) send(57'(i * 7 + 1), z, 1'b1, 1'b0, 1'b0, 7'h00);
      drain();
      check("sat_cnt",    64'(fault_cnt),    64'(255));
      check("sat_sticky", 64'(fault_sticky), 64'(1));
      send(57'h55, z, 1'b1, 1'b1, 1'b0, 7'h00);
      drain();
      check("clrhit_cnt",    64'(fault_cnt),    64'(1));
      check("clrhit_sticky", 64'(fault_sticky), 64'(1));

      // Injection.
      inj_mode = 2'b01; inj_pos = 6'd10;
      arm();
      check("arm_set", 64'(inj_armed), 64'(1));
      m = '0; m[10] = 1'b1;
      send(57'h1F0F0F0F, m, 1'b0, 1'b0, 1'b0, 7'h00);
      check("arm_clr1", 64'(inj_armed), 64'(0));
      send(57'h1F0F0F0F, z, 1'b0, 1'b0, 1'b0, 7'h00);
      inj_mode = 2'b10; inj_pos = 6'd56;
      arm();
      m = '0; m[56] = 1'b1; m[0] = 1'b1;
      send(57'h0, m, 1'b0, 1'b0, 1'b0, 7'h00);
      inj_mode = 2'b01; inj_pos = 6'd60;
      arm();
      check("arm_set60", 64'(inj_armed), 64'(1));
      send(57'h3C3C, z, 1'b0, 1'b0, 1'b0, 7'h00);
      check("arm_clr60", 64'(inj_armed), 64'(0));
      drain();
      inj_mode = 2'b00;

      // Bypass masks parity and compare.
      byp = 1'b1;
      send(57'h77777, z, 1'b1, 1'b0, 1'b0, 7'h00);
      drain();
      check("byp_cnt", 64'(fault_cnt), 64'(1));
      byp = 1'b0;

      // Reset with a stalled, faulted beat and a pending arm.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      send(57'h99, z, 1'b1, 1'b0, 1'b0, 7'h00);
      arm();
      check("pre_rst_vld",   64'(out_vld),   64'(1));
      check("pre_rst_cnt",   64'(fault_cnt), 64'(2));
      check("pre_rst_armed", 64'(inj_armed), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld",    64'(out_vld),      64'(0));
      check("mid_rst_cnt",    64'(fault_cnt),    64'(0));
      check("mid_rst_sticky", 64'(fault_sticky), 64'(0));
      check("mid_rst_armed",  64'(inj_armed),    64'(0));
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      rdy_mode = 0;
      repeat (2) @(posedge clk);
      #1;
      send(57'h1, z, 1'b0, 1'b0, 1'b1, 7'h43);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
